// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronised RxD, centre-sampled bits, one-cycle
// RxD_ready / RxD_frame_err strobes, held output byte.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_ready,
  output logic       RxD_frame_err,
  output logic       RxD_busy,
  output logic [2:0] o_dbg_state
);

  // Output contract: RxD_ready is a one-cycle valid strobe with no ready
  // back-pressure; RxD_data is stable from that cycle until the next strobe.
  // RxD_frame_err never coincides with RxD_ready.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_ready;
  logic             r_ferr;
  logic             w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_timer <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], RxD};
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (!w_rxs) r_state <= S_START;
        end
        S_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (r_timer == HALF_TICK) begin
            r_timer <= '0;
            r_bit   <= 3'd0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_timer == LAST_TICK) begin
            r_timer <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_timer == LAST_TICK) begin
            r_timer <= '0;
            if (w_rxs) begin
              r_data  <= r_shift;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A held-low (break) line must return high before a new frame.
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RxD_data      = r_data;
  assign RxD_ready     = r_ready;
  assign RxD_frame_err = r_ferr;
  assign RxD_busy      = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: two instances (16 and 5 clocks per bit), vector
// table, hand-written corner sequences and randomized frames with a byte model.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx16, rx5;
  logic [7:0] data16, data5;
  logic       rdy16, rdy5, ferr16, ferr5, busy16, busy5;
  logic [2:0] st16, st5;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int rdy_n[2], err_n[2], bl_n[2], bh_n[2];
  int last_rdy_cyc[2], prev_rdy_cyc[2], last_rdy_bl[2], prev_rdy_bl[2];
  int start_cyc[2];
  logic [7:0] prev_d[2];
  logic prev_rst = 1'b1;
  logic [7:0] exp_q16[$];
  logic [7:0] exp_q5[$];

  uart_rx_byte #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .RxD(rx16), .RxD_data(data16), .RxD_ready(rdy16),
    .RxD_frame_err(ferr16), .RxD_busy(busy16), .o_dbg_state(st16));

  uart_rx_byte #(.CLKS_PER_BIT(5)) dut5 (
    .clk(clk), .rst(rst), .RxD(rx5), .RxD_data(data5), .RxD_ready(rdy5),
    .RxD_frame_err(ferr5), .RxD_busy(busy5), .o_dbg_state(st5));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int s, input logic rdy, input logic ferr,
                     input logic [7:0] d, input logic busy);
    logic [7:0] e;
    if (busy === 1'b1) bh_n[s]++; else bl_n[s]++;
    if (ferr === 1'b1) err_n[s]++;
    if (rdy === 1'b1 && ferr === 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL strobe_overlap[%0d]: ready and frame_err both 1", s);
    end
    if (rdy === 1'b1) begin
      rdy_n[s]++;
      prev_rdy_cyc[s] = last_rdy_cyc[s];
      last_rdy_cyc[s] = cyc;
      prev_rdy_bl[s]  = last_rdy_bl[s];
      last_rdy_bl[s]  = bl_n[s];
      if ((s == 0 && exp_q16.size() == 0) || (s == 1 && exp_q5.size() == 0)) begin
        tests_run++; tests_failed++;
        $display("FAIL unexpected_ready[%0d]: got data 0x%0h, expected no strobe", s, d);
      end else begin
        e = (s == 0) ? exp_q16.pop_front() : exp_q5.pop_front();
        check($sformatf("rx_byte[%0d]", s), 32'(d), 32'(e));
      end
    end else if (!(rst || prev_rst) && d !== prev_d[s]) begin
      tests_run++; tests_failed++;
      $display("FAIL data_hold[%0d]: got 0x%0h expected 0x%0h", s, d, prev_d[s]);
    end
    prev_d[s] = d;
  endtask

  always @(negedge clk) begin
    mon(0, rdy16, ferr16, data16, busy16);
    mon(1, rdy5, ferr5, data5, busy5);
    prev_rst = rst;
  end

  // ---------------- driver tasks ----------------
  function automatic int cpb(input int s);
    return (s == 0) ? 16 : 5;
  endfunction

  function automatic logic [7:0] dout(input int s);
    return (s == 0) ? data16 : data5;
  endfunction

  task automatic set_pin(input int s, input logic v);
    if (s == 0) rx16 = v; else rx5 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame slot k spans [k*C*(1+pct/100), (k+1)*C*(1+pct/100)) cycles.
  task automatic send_frame(input int s, input logic [7:0] b, input logic stop, input int pct);
    int c;
    logic [9:0] fr;
    c = cpb(s);
    fr = {stop, b, 1'b0};
    start_cyc[s] = cyc;
    for (int k = 0; k < 10; k++) begin
      int len;
      len = ((k + 1) * c * (100 + pct)) / 100 - (k * c * (100 + pct)) / 100;
      set_pin(s, fr[k]);
      repeat (len) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy(input int s, input int target, input int budget);
    int k;
    k = 0;
    while (rdy_n[s] < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (rdy_n[s] < target) begin
      tests_run++; tests_failed++;
      $display("FAIL ready_timeout[%0d]: got %0d strobes expected %0d", s, rdy_n[s], target);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic [7:0] din;
    int         pct;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int r0, e0, b0, h0, c, h;
    int exp_rdy[2], exp_err[2];

    vecs[0] = '{0, 8'hA5,  0, 8'hA5, 2 + 8 + 144 + 1};
    vecs[1] = '{0, 8'h00,  3, 8'h00, -1};
    vecs[2] = '{0, 8'h00, -3, 8'h00, -1};
    vecs[3] = '{0, 8'hFF,  3, 8'hFF, -1};
    vecs[4] = '{0, 8'hFF, -3, 8'hFF, -1};
    vecs[5] = '{1, 8'h00,  3, 8'h00, -1};
    vecs[6] = '{1, 8'h00, -3, 8'h00, -1};
    vecs[7] = '{1, 8'hFF,  3, 8'hFF, -1};
    vecs[8] = '{1, 8'hFF, -3, 8'hFF, -1};
    vecs[9] = '{1, 8'hA5,  0, 8'hA5, 2 + 2 + 45 + 1};

    rst = 1'b1; rx16 = 1'b1; rx5 = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_data16", 32'(data16), 32'h00);
    check("reset_ready16", 32'(rdy16), 0);
    check("reset_ferr16", 32'(ferr16), 0);
    check("reset_busy16", 32'(busy16), 0);
    check("reset_state16", 32'(st16), 0);
    check("reset_data5", 32'(data5), 32'h00);
    check("reset_busy5", 32'(busy5), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      c = cpb(vecs[i].sel);
      r0 = rdy_n[vecs[i].sel];
      e0 = err_n[vecs[i].sel];
      if (vecs[i].sel == 0) exp_q16.push_back(vecs[i].din);
      else exp_q5.push_back(vecs[i].din);
      send_frame(vecs[i].sel, vecs[i].din, 1'b1, vecs[i].pct);
      wait_rdy(vecs[i].sel, r0 + 1, 4 * c);
      idle(2 * c);
      check($sformatf("vec%0d_data", i), 32'(dout(vecs[i].sel)), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_one_ready", i), rdy_n[vecs[i].sel] - r0, 1);
      check($sformatf("vec%0d_no_ferr", i), err_n[vecs[i].sel] - e0, 0);
      if (vecs[i].exp_lat >= 0)
        check($sformatf("vec%0d_latency", i),
              last_rdy_cyc[vecs[i].sel] - start_cyc[vecs[i].sel], vecs[i].exp_lat);
    end

    // Back-to-back frames with no idle gap.
    c = 16; h = 8;
    r0 = rdy_n[0];
    exp_q16.push_back(8'h12);
    exp_q16.push_back(8'h34);
    send_frame(0, 8'h12, 1'b1, 0);
    send_frame(0, 8'h34, 1'b1, 0);
    wait_rdy(0, r0 + 2, 4 * c);
    idle(2 * c);
    check("b2b_count", rdy_n[0] - r0, 2);
    check("b2b_spacing", last_rdy_cyc[0] - prev_rdy_cyc[0], 10 * c);
    check("b2b_busy_low_window", last_rdy_bl[0] - prev_rdy_bl[0], c - h);
    check("b2b_last_data", 32'(data16), 32'h34);

    // Short low glitch on an idle line.
    r0 = rdy_n[0]; e0 = err_n[0]; h0 = bh_n[0];
    set_pin(0, 1'b0);
    idle(4);
    set_pin(0, 1'b1);
    idle(3 * c);
    b0 = bh_n[0] - h0;
    check("glitch_busy_len_ok", 32'(b0 >= h && b0 <= h + 1), 1);
    check("glitch_no_ready", rdy_n[0] - r0, 0);
    check("glitch_no_ferr", err_n[0] - e0, 0);
    check("glitch_data_held", 32'(data16), 32'h34);

    // Stop bit low, then a long break.
    r0 = rdy_n[0]; e0 = err_n[0];
    send_frame(0, 8'h55, 1'b0, 0);
    idle(40 * c);
    check("break_one_ferr", err_n[0] - e0, 1);
    check("break_no_ready", rdy_n[0] - r0, 0);
    check("break_data_held", 32'(data16), 32'h34);
    set_pin(0, 1'b1);
    idle(2 * c);
    check("break_no_extra_ferr", err_n[0] - e0, 1);
    exp_q16.push_back(8'h3C);
    send_frame(0, 8'h3C, 1'b1, 0);
    wait_rdy(0, r0 + 1, 4 * c);
    idle(c);
    check("after_break_data", 32'(data16), 32'h3C);

    // Reset in the middle of data bit 4.
    r0 = rdy_n[0]; e0 = err_n[0];
    fork
      send_frame(0, 8'hF0, 1'b1, 0);
      begin
        repeat (5 * c + h) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_data", 32'(data16), 32'h00);
        check("midreset_ready", 32'(rdy16), 0);
        check("midreset_ferr", 32'(ferr16), 0);
        check("midreset_busy", 32'(busy16), 0);
      end
    join
    idle(2 * c);
    check("midreset_no_strobe", rdy_n[0] - r0 + err_n[0] - e0, 0);
    exp_q16.push_back(8'hC3);
    send_frame(0, 8'hC3, 1'b1, 0);
    wait_rdy(0, r0 + 1, 4 * c);
    idle(c);
    check("after_reset_data", 32'(data16), 32'hC3);

    // Randomized frames against the byte/strobe model.
    exp_rdy[0] = rdy_n[0]; exp_rdy[1] = rdy_n[1];
    exp_err[0] = err_n[0]; exp_err[1] = err_n[1];
    for (int i = 0; i < 30; i++) begin
      int s, pct, gap;
      logic [7:0] b;
      logic stop;
      s    = int'($urandom_range(0, 1));
      b    = 8'($urandom);
      pct  = int'($urandom_range(0, 6)) - 3;
      stop = ($urandom_range(0, 5) != 0);
      c    = cpb(s);
      gap  = stop ? int'($urandom_range(1, 2 * c)) : c + int'($urandom_range(0, c));
      if (stop) begin
        exp_rdy[s]++;
        if (s == 0) exp_q16.push_back(b); else exp_q5.push_back(b);
      end else begin
        exp_err[s]++;
      end
      send_frame(s, b, stop, pct);
      set_pin(s, 1'b1);
      idle(gap);
    end
    idle(3 * 16);
    check("rand_ready16", rdy_n[0], exp_rdy[0]);
    check("rand_ready5", rdy_n[1], exp_rdy[1]);
    check("rand_ferr16", err_n[0], exp_err[0]);
    check("rand_ferr5", err_n[1], exp_err[1]);
    check("queue16_drained", exp_q16.size(), 0);
    check("queue5_drained", exp_q5.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial receiver front end that deserialises 8N1 asynchronous UART frames on the RxD pin into bytes. It sits directly upstream of the receive control unit, which assembles byte pairs into 16-bit FIR samples. It presents each good byte on RxD_data together with a one-cycle RxD_ready strobe, and flags framing errors separately. Single clock domain; the RxD pin is asynchronous and is synchronised internally.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 4
CNT_W, $clog2(CLKS_PER_BIT), bit-timer width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
RxD  input  1  asynchronous serial line, idle high
RxD_data  output  8  last correctly framed byte, LSB received first
RxD_ready  output  1  one-cycle pulse: new byte valid on RxD_data this cycle
RxD_frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
RxD_busy  output  1  high while a frame is being received (any state except IDLE)

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high on clk/rst.
- Synchroniser: 2-FF on RxD, reset value 1; rxs = second stage. All decisions use rxs only.
- Reset values: RxD_data=8'h00, RxD_ready=0, RxD_frame_err=0, RxD_busy=0, state=IDLE, bit timer=0, bit index=0. Reset mid-frame abandons the frame with no strobe.
- Timing references: C = CLKS_PER_BIT, H = C/2 (integer floor). t0 = first cycle IDLE sees rxs==0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: timer held at 0. rxs==0 -> START, timer cleared.
- START: timer counts. At t0+H, sample rxs. If 0 -> DATA with timer=0 and bit index=0. If 1 (glitch) -> IDLE with no strobe.
- DATA: data bit k (k=0..7) is sampled at t0+H+(k+1)*C and shifted into the MSB of the shift register, shifting right, so bit 0 ends at RxD_data[0]. After k=7 -> STOP.
- STOP: sample at t0+H+9*C.
  - If rxs==1: load shift register into RxD_data and pulse RxD_ready in the next cycle -> IDLE.
  - If rxs==0: pulse RxD_frame_err in the next cycle, leave RxD_data unchanged -> WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then -> IDLE. A held-low line (break) must not generate repeated frames.
- Strobes: RxD_ready and RxD_frame_err are registered and never high together. Each lasts exactly 1 cycle.
- RxD_data stability: RxD_data changes only in the RxD_ready cycle and is held until the next good byte.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted. IDLE is re-entered H cycles into the stop bit, so no start edge is missed.
- Latency: from the falling start edge on the RxD pin to RxD_ready is 2 + H + 9*C + 1 cycles.
- Throughput: one byte per 10*C cycles minimum spacing between strobes.
- Baud tolerance: the receiver tolerates ±4% baud mismatch by centre sampling. No resynchronisation occurs within a frame.
- RxD_busy: equals (state != IDLE), registered with the state.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA5 at exact baud -> single 1-cycle RxD_ready at 2+8+144+1 = 155 cycles after the start edge, RxD_data=8'hA5, RxD_frame_err stays 0.
- Back-to-back 0x12 then 0x34 with no idle gap -> two RxD_ready pulses 160 cycles apart; RxD_data=8'h12, then 8'h34; RxD_busy high across both frames except the brief IDLE window.
- 4-cycle low glitch on an idle line -> no strobe; RxD_busy high for about 9 cycles, then 0; RxD_data unchanged.
- Send 0x55 with the stop bit driven 0, then hold the line low for 40 bit times -> exactly one RxD_frame_err pulse, no RxD_ready, RxD_data keeps its previous value; the next valid 0x3C after the line returns high is received correctly.
- Assert rst at data bit 4 of a frame -> all outputs 0 on the next cycle and no strobe for that frame; a following 0xC3 is received correctly.
- Boundary bytes 0x00 and 0xFF, plus CLKS_PER_BIT=5 (odd, H=2), each sent at ±3% baud -> correct data and a single RxD_ready per frame.
